// File: rtl/siren_sweep_ctrl.sv
// Siren pitch sequencer: sweeps the speaker tone half-period according to the
// synchronised siren mode (off / wail / yelp / hi-lo).
module siren_sweep_ctrl #(
  parameter int unsigned HP_MAX        = 83333,
  parameter int unsigned HP_MIN        = 35714,
  parameter int unsigned HP_STEP       = 476,
  parameter int unsigned WAIL_STEP_CYC = 2_000_000,
  parameter int unsigned YELP_STEP_CYC = 200_000,
  parameter int unsigned HILO_HOLD_CYC = 50_000_000,
  parameter int unsigned TONE_W        = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  output logic              tone_en,
  output logic [TONE_W-1:0] half_period,
  output logic              upd
);

  localparam int unsigned AW      = TONE_W + 1;
  localparam int unsigned CYC_WY  = (WAIL_STEP_CYC > YELP_STEP_CYC) ? WAIL_STEP_CYC : YELP_STEP_CYC;
  localparam int unsigned MAX_CYC = (CYC_WY > HILO_HOLD_CYC) ? CYC_WY : HILO_HOLD_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [AW-1:0] MAX_X  = AW'(HP_MAX);
  localparam logic [AW-1:0] MIN_X  = AW'(HP_MIN);
  localparam logic [AW-1:0] STEP_X = AW'(HP_STEP);

  localparam logic [CW-1:0] WAIL_LAST = CW'(WAIL_STEP_CYC - 1);
  localparam logic [CW-1:0] YELP_LAST = CW'(YELP_STEP_CYC - 1);
  localparam logic [CW-1:0] HILO_LAST = CW'(HILO_HOLD_CYC - 1);

  localparam logic [1:0] M_OFF  = 2'b00;
  localparam logic [1:0] M_WAIL = 2'b01;
  localparam logic [1:0] M_YELP = 2'b10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RISE = 3'd1;
  localparam logic [2:0] S_FALL = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_HI   = 3'd4;

  logic [1:0]        mode_meta_q, mode_meta_d;
  logic [1:0]        mode_s_q, mode_s_d;
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TONE_W-1:0] hp_q, hp_d;
  logic              tone_en_q, tone_en_d;
  logic              upd_q, upd_d;

  logic [CW-1:0]     cnt_last;
  logic              tick;
  logic [AW-1:0]     hp_ext, hp_dn, hp_up;

  // Next-state, prescaler and pitch update; a mode change beats a tick.
  always_comb begin
    mode_meta_d = mode;
    mode_s_d    = mode_meta_q;
    mode_d      = mode_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    hp_d        = hp_q;
    tone_en_d   = tone_en_q;
    upd_d       = 1'b0;
    tick        = 1'b0;
    hp_ext      = {1'b0, hp_q};
    hp_dn       = hp_ext - STEP_X;
    hp_up       = hp_ext + STEP_X;

    case (mode_q)
      M_WAIL:  cnt_last = WAIL_LAST;
      M_YELP:  cnt_last = YELP_LAST;
      M_OFF:   cnt_last = CW'(0);
      default: cnt_last = HILO_LAST;
    endcase

    if (mode_s_q != mode_q) begin
      mode_d = mode_s_q;
      cnt_d  = CW'(0);
      hp_d   = TONE_W'(HP_MAX);
      case (mode_s_q)
        M_OFF: begin
          state_d   = S_IDLE;
          tone_en_d = 1'b0;
        end
        M_WAIL, M_YELP: begin
          state_d   = S_RISE;
          tone_en_d = 1'b1;
          upd_d     = 1'b1;
        end
        default: begin
          state_d   = S_LO;
          tone_en_d = 1'b1;
          upd_d     = 1'b1;
        end
      endcase
    end else if (state_q == S_IDLE) begin
      cnt_d = CW'(0);
    end else begin
      if (cnt_q == cnt_last) begin
        cnt_d = CW'(0);
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      if (tick) begin
        upd_d = 1'b1;
        case (state_q)
          S_RISE: begin
            // hp_ext < STEP_X guards the subtraction against underflow
            if ((hp_ext < STEP_X) || (hp_dn <= MIN_X)) begin
              hp_d    = TONE_W'(HP_MIN);
              state_d = S_FALL;
            end else begin
              hp_d = TONE_W'(hp_dn);
            end
          end
          S_FALL: begin
            if (hp_up >= MAX_X) begin
              hp_d    = TONE_W'(HP_MAX);
              state_d = S_RISE;
            end else begin
              hp_d = TONE_W'(hp_up);
            end
          end
          S_LO: begin
            hp_d    = TONE_W'(HP_MIN);
            state_d = S_HI;
          end
          S_HI: begin
            hp_d    = TONE_W'(HP_MAX);
            state_d = S_LO;
          end
          default: begin
            hp_d      = TONE_W'(HP_MAX);
            state_d   = S_IDLE;
            tone_en_d = 1'b0;
            upd_d     = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_meta_q <= 2'b00;
      mode_s_q    <= 2'b00;
      mode_q      <= 2'b00;
      state_q     <= S_IDLE;
      cnt_q       <= CW'(0);
      hp_q        <= TONE_W'(HP_MAX);
      tone_en_q   <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      mode_meta_q <= mode_meta_d;
      mode_s_q    <= mode_s_d;
      mode_q      <= mode_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hp_q        <= hp_d;
      tone_en_q   <= tone_en_d;
      upd_q       <= upd_d;
    end
  end

  assign tone_en     = tone_en_q;
  assign half_period = hp_q;
  assign upd         = upd_q;

endmodule

// File: doc/siren_sweep_ctrl.md
# siren_sweep_ctrl

Pitch sequencer for the police-siren audio path. Generates the tone half-period (in clock cycles) that the downstream square-wave speaker stage toggles on, sweeping it over time according to the selected siren mode: off, wail, yelp or hi-lo. It owns mode synchronisation, sweep timing and endpoint clamping. The speaker stage only consumes `half_period`, `tone_en` and the `upd` strobe.

## Interface
- `HP_MAX`, 83333: half-period of the lowest pitch (600 Hz at 100 MHz); sweep start point.
- `HP_MIN`, 35714: half-period of the highest pitch (1400 Hz).
- `HP_STEP`, 476: half-period change per sweep step; must be > 0 with HP_MIN < HP_MAX.
- `WAIL_STEP_CYC`, 2_000_000: clocks per step in wail mode.
- `YELP_STEP_CYC`, 200_000: clocks per step in yelp mode.
- `HILO_HOLD_CYC`, 50_000_000: clocks per tone in hi-lo mode.
- `TONE_W`, 17: width of `half_period`; must hold HP_MAX.
- `clk` in 1: system clock (100 MHz board clock).
- `rst_n` in 1: asynchronous, active-low reset.
- `mode` in 2: siren select. 00 off, 01 wail, 10 yelp, 11 hi-lo. Asynchronous to `clk` (switches).
- `tone_en` out 1: high while any siren mode is active.
- `half_period` out TONE_W: current tone half-period in clocks.
- `upd` out 1: one-cycle strobe on every cycle in which `half_period` was loaded.

## Operation
- `mode` passes through a 2-flop synchroniser (`mode_s`). A registered copy `mode_q` is kept; `mode_s != mode_q` is a mode change.
- States:
  - IDLE (off)
  - RISE (pitch rising: hp decreasing)
  - FALL (pitch falling: hp increasing)
  - LO (hp = HP_MAX)
  - HI (hp = HP_MIN)
- On a mode change, the block loads `mode_q <= mode_s` and clears the prescaler. Then:
  - 00 → IDLE, `tone_en`=0, hp=HP_MAX, no `upd`.
  - 01/10 → RISE, hp=HP_MAX, `tone_en`=1, `upd`=1.
  - 11 → LO, hp=HP_MAX, `tone_en`=1, `upd`=1.
- The sweep always restarts from HP_MAX, including on wail↔yelp changes.
- Prescaler counts 0..N-1:
  - N = WAIL_STEP_CYC in wail, YELP_STEP_CYC in yelp, HILO_HOLD_CYC in hi-lo.
  - The tick occurs at count N-1; the count wraps to 0 on the same edge.
  - In IDLE the prescaler is held at 0.
- RISE tick: if hp − HP_STEP ≤ HP_MIN, then hp=HP_MIN and go to FALL; otherwise hp −= HP_STEP.
- FALL tick: if hp + HP_STEP ≥ HP_MAX, then hp=HP_MAX and go to RISE; otherwise hp += HP_STEP.
- LO tick → HI with hp=HP_MIN. HI tick → LO with hp=HP_MAX.
- Arithmetic is done at TONE_W+1 bits (compare before assigning), so there is no wrap-around. hp never leaves [HP_MIN, HP_MAX].
- A mode change takes priority over a tick in the same cycle.
- Prescaler width is $clog2 of the largest step parameter.

## Timing
- Reset values: `tone_en`=0, `half_period`=HP_MAX, `upd`=0, state IDLE, `mode_q`=00, prescaler 0, synchroniser 00.
- Reset is asynchronous; assertion mid-sweep forces reset values immediately.
- Mode latency: a `mode` change before edge k is visible at the outputs after edge k+2 (third rising edge). `upd` is high for the cycle following that edge.
- Step latency: with the mode stable, the first step loads N clocks after the entry edge, then every N clocks. `upd` is high for exactly the one cycle after each load.
- Wail/yelp full sweep period: 2·ceil((HP_MAX−HP_MIN)/HP_STEP) steps.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
Use HP_MAX=100, HP_MIN=40, HP_STEP=25, WAIL_STEP_CYC=8, YELP_STEP_CYC=2, HILO_HOLD_CYC=16.

1. Reset, then hold `mode`=00 for 50 clocks → `tone_en`=0, `half_period`=100, `upd` never pulses.
2. `mode`=01 → after 3 edges, `tone_en`=1, hp=100, `upd` pulse. Then every 8 clocks hp = 75, 50, 40, 65, 90, 100, 75; one `upd` per value.
3. `mode`=10 → same value sequence at a 2-clock spacing. Switch to 01 mid-sweep (hp=50) → after 3 edges hp=100, state RISE, next step 8 clocks later gives 75.
4. `mode`=11 → hp=100 for 16 clocks, then 40 for 16 clocks, then 100, repeating. `upd` pulses at each toggle.
5. Mode change on the same cycle as a tick (01→11 with the prescaler at 7) → hp=100 in LO, no step applied.
6. Assert `rst_n`=0 mid-sweep at hp=65 → immediately `tone_en`=0, hp=100, `upd`=0. After release with `mode`=01 held → restart from 100 after 3 edges.
